// File: rtl/riego_bomba_seq.sv
// Pump/valve relay sequencer for the irrigation controller: prime, min/max run,
// cooldown, dry-run fault latch and a saturating pump runtime counter (1 cycle = 1 s).
module riego_bomba_seq #(
    parameter int unsigned PRIME_S   = 3,
    parameter int unsigned MIN_ON_S  = 10,
    parameter int unsigned MAX_ON_S  = 300,
    parameter int unsigned MIN_OFF_S = 30,
    parameter int unsigned DRY_S     = 2,
    parameter int unsigned TEMP_HI   = 6
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        ON,
    input  logic        REQ,
    input  logic        AGUA,
    input  logic [2:0]  TEMP,
    output logic        VALVE,
    output logic        PUMP,
    output logic        FAULT,
    output logic [2:0]  STATE,
    output logic [15:0] RUNTIME
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_RUN   = 3'd2,
        S_COOL  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    // Timer t holds (cycles already spent in the state - 1) when an edge is evaluated,
    // so "lasted N cycles" is t >= N-1. All timing parameters are expected to be >= 1.
    localparam logic [15:0] PRIME_LAST = 16'(PRIME_S - 1);
    localparam logic [15:0] MIN_LAST   = 16'(MIN_ON_S - 1);
    localparam logic [15:0] MAX_LAST   = 16'(MAX_ON_S - 1);
    localparam logic [15:0] OFF_LAST   = 16'(MIN_OFF_S - 1);
    localparam logic [15:0] DRY_LIM    = 16'(DRY_S);

    state_t      state, state_next;
    logic [15:0] t;
    logic [15:0] d, d_next;
    logic        start_ok;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign start_ok = ON && REQ && AGUA && (32'(TEMP) < TEMP_HI);

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        d_next     = '0;
        case (state)
            S_IDLE: begin
                if (start_ok) state_next = S_PRIME;
            end
            S_PRIME: begin
                if (!ON || !REQ || !AGUA)  state_next = S_IDLE;
                else if (t >= PRIME_LAST)  state_next = S_RUN;
            end
            S_RUN: begin
                d_next = AGUA ? 16'd0 : sat_inc(d);
                if (!AGUA && (d_next >= DRY_LIM))  state_next = S_FAULT;
                else if (!ON)                      state_next = S_COOL;
                else if (t >= MAX_LAST)            state_next = S_COOL;
                else if (!REQ && (t >= MIN_LAST))  state_next = S_COOL;
            end
            S_COOL: begin
                if (t >= OFF_LAST) state_next = S_IDLE;
            end
            S_FAULT: begin
                if (!ON) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state   <= S_IDLE;
            t       <= '0;
            d       <= '0;
            RUNTIME <= '0;
        end else begin
            state <= state_next;
            t     <= (state_next != state) ? 16'd0 : sat_inc(t);
            d     <= (state_next == S_RUN) ? d_next : 16'd0;
            if (state == S_RUN) RUNTIME <= sat_inc(RUNTIME);
        end
    end

    // Moore decode: relays depend only on the registered state.
    assign VALVE = (state == S_PRIME) || (state == S_RUN);
    assign PUMP  = (state == S_RUN);
    assign FAULT = (state == S_FAULT);
    assign STATE = state;

endmodule

// File: tb/tb_riego_bomba_seq.sv
// Bench for riego_bomba_seq: directed scenarios plus a randomized run, all
// checked against a cycle-level model of the sequencing rules.
module tb_riego_bomba_seq;

    localparam int PRIME_S = 3, MIN_ON_S = 10, MAX_ON_S = 300;
    localparam int MIN_OFF_S = 30, DRY_S = 2, TEMP_HI = 6;

    logic        CLK;
    logic        RSTN, ON, REQ, AGUA;
    logic [2:0]  TEMP;
    logic        VALVE, PUMP, FAULT;
    logic [2:0]  STATE;
    logic [15:0] RUNTIME;

    int total = 0;
    int bad   = 0;

    // model: mode code, cycles completed in mode, consecutive dry cycles, runtime
    int m_state, m_secs, m_dry, m_runtime;

    riego_bomba_seq dut (
        .CLK(CLK), .RSTN(RSTN), .ON(ON), .REQ(REQ), .AGUA(AGUA), .TEMP(TEMP),
        .VALVE(VALVE), .PUMP(PUMP), .FAULT(FAULT), .STATE(STATE), .RUNTIME(RUNTIME)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_step();
        int done_secs;
        int nxt;
        if (!RSTN) begin
            m_state = 0; m_secs = 0; m_dry = 0; m_runtime = 0;
            return;
        end
        done_secs = m_secs + 1;
        nxt = m_state;
        if (m_state == 2 && m_runtime < 65535) m_runtime++;
        case (m_state)
            0: if (ON && REQ && AGUA && int'(TEMP) < TEMP_HI) nxt = 1;
            1: begin
                if (!ON || !REQ || !AGUA) nxt = 0;
                else if (done_secs == PRIME_S) nxt = 2;
            end
            2: begin
                m_dry = AGUA ? 0 : m_dry + 1;
                if (m_dry >= DRY_S) nxt = 4;
                else if (!ON) nxt = 3;
                else if (done_secs >= MAX_ON_S) nxt = 3;
                else if (!REQ && done_secs >= MIN_ON_S) nxt = 3;
            end
            3: if (done_secs >= MIN_OFF_S) nxt = 0;
            4: if (!ON) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt != m_state) begin
            m_state = nxt; m_secs = 0; m_dry = 0;
        end else begin
            m_secs = done_secs;
        end
    endtask

    function automatic logic [21:0] exp_vec();
        return {(m_state == 1 || m_state == 2), (m_state == 2), (m_state == 4),
                3'(m_state), 16'(m_runtime)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        RSTN = 1'b0; ON = 1'b0; REQ = 1'b0; AGUA = 1'b0; TEMP = 3'd0;
        repeat (2) tick();
        RSTN = 1'b1;
    endtask

    task automatic test_reset();
        RSTN = 1'b0; ON = 1'bx; REQ = 1'bx; AGUA = 1'bx; TEMP = 3'bxxx;
        #2;
        ON = 1'b0; REQ = 1'b0; AGUA = 1'b0; TEMP = 3'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({VALVE, PUMP, FAULT, STATE, RUNTIME} !== 22'd0) begin
                bad++;
                $display("FAIL reset cyc%0d: got %h want 0", i, {VALVE, PUMP, FAULT, STATE, RUNTIME});
            end
        end
        RSTN = 1'b1;
    endtask

    task automatic test_min_on();
        int valve_at = -1, pump_at = -1, pump_cyc = 0, cool_cyc = 0;
        bit done = 0;
        do_reset();
        ON = 1; AGUA = 1; TEMP = 3'd2; REQ = 1;
        for (int i = 1; i <= 120 && !done; i++) begin
            tick();
            total++;
            if ({VALVE, PUMP, FAULT, STATE, RUNTIME} !== exp_vec()) begin
                bad++;
                $display("FAIL min_on cyc%0d: got %h want %h", i, {VALVE, PUMP, FAULT, STATE, RUNTIME}, exp_vec());
            end
            if (VALVE && valve_at < 0) valve_at = i;
            if (PUMP && pump_at < 0) pump_at = i;
            if (PUMP) pump_cyc++;
            if (STATE == 3'd3) cool_cyc++;
            if (pump_cyc == 5) REQ = 0;
            if (cool_cyc > 0 && STATE == 3'd0) done = 1;
        end
        total++;
        if (valve_at !== 1 || pump_at !== 4) begin
            bad++;
            $display("FAIL min_on_start: valve_at=%0d pump_at=%0d want 1 and 4", valve_at, pump_at);
        end
        total++;
        if (pump_cyc !== MIN_ON_S || cool_cyc !== MIN_OFF_S || !done) begin
            bad++;
            $display("FAIL min_on_len: run=%0d cool=%0d done=%0d want %0d %0d 1", pump_cyc, cool_cyc, done, MIN_ON_S, MIN_OFF_S);
        end
        total++;
        if (RUNTIME !== 16'd10) begin
            bad++;
            $display("FAIL min_on_runtime: got %0d want 10", RUNTIME);
        end
    endtask

    task automatic test_max_on();
        int pump_cyc = 0, cool_cyc = 0;
        bit done = 0;
        do_reset();
        ON = 1; AGUA = 1; TEMP = 3'd0; REQ = 1;
        for (int i = 1; i <= 400 && !done; i++) begin
            tick();
            total++;
            if ({VALVE, PUMP, FAULT, STATE, RUNTIME} !== exp_vec()) begin
                bad++;
                $display("FAIL max_on cyc%0d: got %h want %h", i, {VALVE, PUMP, FAULT, STATE, RUNTIME}, exp_vec());
            end
            if (PUMP) pump_cyc++;
            if (STATE == 3'd3) cool_cyc++;
            if (cool_cyc > 0 && STATE == 3'd0) done = 1;
        end
        total++;
        if (pump_cyc !== MAX_ON_S || cool_cyc !== MIN_OFF_S || !done || RUNTIME !== 16'd300) begin
            bad++;
            $display("FAIL max_on_len: run=%0d cool=%0d done=%0d runtime=%0d want 300 30 1 300", pump_cyc, cool_cyc, done, RUNTIME);
        end
        tick();
        total++;
        if (STATE !== 3'd1 || !VALVE) begin
            bad++;
            $display("FAIL max_on_restart: state=%0d valve=%0d want 1 1", STATE, VALVE);
        end
    endtask

    task automatic test_dry_fault();
        int agua_pat[4]  = '{0, 1, 0, 0};
        int state_pat[4] = '{2, 2, 2, 4};
        do_reset();
        ON = 1; AGUA = 1; TEMP = 3'd1; REQ = 1;
        for (int i = 0; i < 10 && !PUMP; i++) tick();
        total++;
        if (PUMP !== 1'b1) begin
            bad++;
            $display("FAIL dry_reach_run: pump=%0d want 1", PUMP);
        end
        for (int k = 0; k < 4; k++) begin
            AGUA = agua_pat[k][0];
            tick();
            total++;
            if (int'(STATE) !== state_pat[k] || {VALVE, PUMP, FAULT, STATE, RUNTIME} !== exp_vec()) begin
                bad++;
                $display("FAIL dry_step%0d: state=%0d want %0d (vec %h want %h)", k, STATE, state_pat[k], {VALVE, PUMP, FAULT, STATE, RUNTIME}, exp_vec());
            end
        end
        AGUA = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (PUMP !== 1'b0 || FAULT !== 1'b1 || STATE !== 3'd4) begin
                bad++;
                $display("FAIL dry_hold%0d: pump=%0d fault=%0d state=%0d want 0 1 4", k, PUMP, FAULT, STATE);
            end
        end
        ON = 0;
        tick();
        total++;
        if (FAULT !== 1'b0 || STATE !== 3'd0 || {VALVE, PUMP, FAULT, STATE, RUNTIME} !== exp_vec()) begin
            bad++;
            $display("FAIL dry_clear: fault=%0d state=%0d want 0 0", FAULT, STATE);
        end
    endtask

    task automatic test_temp_prime();
        logic [2:0] hot[3] = '{3'd6, 3'd7, 3'd6};
        do_reset();
        ON = 1; AGUA = 1; REQ = 1;
        for (int k = 0; k < 3; k++) begin
            TEMP = hot[k];
            tick();
            total++;
            if (STATE !== 3'd0 || VALVE !== 1'b0) begin
                bad++;
                $display("FAIL temp_inhibit temp=%0d: state=%0d want 0", TEMP, STATE);
            end
        end
        TEMP = 3'd5;
        tick();
        total++;
        if (STATE !== 3'd1 || VALVE !== 1'b1) begin
            bad++;
            $display("FAIL temp_start: state=%0d want 1", STATE);
        end
        AGUA = 0;
        tick();
        total++;
        if (STATE !== 3'd0 || FAULT !== 1'b0 || VALVE !== 1'b0) begin
            bad++;
            $display("FAIL prime_abort: state=%0d fault=%0d want 0 0", STATE, FAULT);
        end
        AGUA = 1;
        tick();
        total++;
        if (STATE !== 3'd1 || {VALVE, PUMP, FAULT, STATE, RUNTIME} !== exp_vec()) begin
            bad++;
            $display("FAIL prime_no_cool: state=%0d want 1", STATE);
        end
    endtask

    task automatic test_on_drop_reset();
        do_reset();
        ON = 1; AGUA = 1; TEMP = 3'd3; REQ = 1;
        for (int i = 0; i < 10 && !PUMP; i++) tick();
        repeat (2) tick();
        total++;
        if (PUMP !== 1'b1 || RUNTIME !== 16'd2) begin
            bad++;
            $display("FAIL ondrop_run3: pump=%0d runtime=%0d want 1 2", PUMP, RUNTIME);
        end
        ON = 0;
        tick();
        total++;
        if (STATE !== 3'd3 || PUMP !== 1'b0 || RUNTIME !== 16'd3) begin
            bad++;
            $display("FAIL ondrop_cool: state=%0d pump=%0d runtime=%0d want 3 0 3", STATE, PUMP, RUNTIME);
        end
        ON = 1;
        repeat (3) tick();
        total++;
        if (STATE !== 3'd3) begin
            bad++;
            $display("FAIL cool_no_restart: state=%0d want 3", STATE);
        end
        RSTN = 0;
        tick();
        total++;
        if (STATE !== 3'd0 || RUNTIME !== 16'd0 || PUMP !== 1'b0) begin
            bad++;
            $display("FAIL cool_reset: state=%0d runtime=%0d want 0 0", STATE, RUNTIME);
        end
        RSTN = 1;
    endtask

    task automatic test_random();
        logic [4:0] seen = '0;
        do_reset();
        REQ = 0;
        for (int i = 0; i < 6000; i++) begin
            RSTN = ($urandom_range(0, 299) != 0);
            ON   = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 19) == 0) REQ = ~REQ;
            AGUA = ($urandom_range(0, 9) != 0);
            TEMP = 3'($urandom_range(0, 7));
            tick();
            total++;
            if ({VALVE, PUMP, FAULT, STATE, RUNTIME} !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc%0d: got %h want %h", i, {VALVE, PUMP, FAULT, STATE, RUNTIME}, exp_vec());
            end
            if (m_state < 5) seen[m_state] = 1'b1;
        end
        total++;
        if (seen !== 5'b11111) begin
            bad++;
            $display("FAIL random_cover: states seen %b want 11111", seen);
        end
        RSTN = 1;
    endtask

    initial begin
        m_state = 0; m_secs = 0; m_dry = 0; m_runtime = 0;
        test_reset();
        test_min_on();
        test_max_on();
        test_dry_fault();
        test_temp_prime();
        test_on_drop_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
